// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family: digit width, digit limit,
// controller state encoding and the load-time digit clamp.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Out-of-range nibbles saturate to 9 so the count register only ever holds valid BCD.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement with borrow: 0 with an incoming borrow wraps to 9
// and passes the borrow on to the next digit.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: load/start/pause control, prescaled
// decrement with digit-wise borrow, and a one-cycle done pulse at zero.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    busy,
  output logic                    done
);

  localparam int W    = BCD_W * DIGITS;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Handshake: load, start and pause are level-sampled single-cycle commands,
  // acted on at the rising edge where they are high (rst > load > pause > start).
  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    count_dec;
  logic [W-1:0]    load_clamped;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            done_q, done_d;
  logic            tick;
  logic            dec_zero;
  logic [DIGITS:0] borrow;

  assign tick      = (state_q == ST_RUN) && !load && !pause && (presc_q == PS_LAST);
  assign borrow[0] = tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_dec (
      .digit      (count_q[g*BCD_W +: BCD_W]),
      .borrow_in  (borrow[g]),
      .digit_next (count_dec[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
    assign load_clamped[g*BCD_W +: BCD_W] = clamp_digit(load_val[g*BCD_W +: BCD_W]);
  end

  // A borrow out of the top digit would mean wrapping below zero; treat it as
  // reaching zero so the count can never roll over to all nines.
  assign dec_zero = (count_dec == '0) || borrow[DIGITS];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_clamped;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (count_q == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            presc_d = '0;
            if (dec_zero) begin
              count_d = '0;
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              count_d = count_dec;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_PAUSED: begin
          if (start && !pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign bcd_out = count_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: two instances (PRESCALE 1 and 4) on shared stimulus,
// checked against an integer-valued countdown model plus directed expectations.
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] bcd1, bcd4;
  logic         busy1, busy4, done1, done4;

  int   tests = 0;
  int   fails = 0;
  int   m_val [2] = '{0, 0};
  int   m_mode[2] = '{M_IDLE, M_IDLE};
  int   m_ps  [2] = '{0, 0};
  logic m_done[2] = '{1'b0, 1'b0};
  int   psc   [2] = '{1, 4};

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(DIGITS), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .bcd_out(bcd1), .busy(busy1), .done(done1)
  );

  bcd_down_timer #(.DIGITS(DIGITS), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .bcd_out(bcd4), .busy(busy4), .done(done4)
  );

  function automatic int clamp_value(input logic [W-1:0] v);
    int s, mul, dig;
    s = 0;
    mul = 1;
    for (int d = 0; d < DIGITS; d++) begin
      dig = int'(v[d*4 +: 4]);
      if (dig > 9) dig = 9;
      s += dig * mul;
      mul *= 10;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int rem;
    r = '0;
    rem = n;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  function automatic logic [W+1:0] model_out(input int i);
    return {to_bcd(m_val[i]), (m_mode[i] == M_RUN) || (m_mode[i] == M_PAUSED), m_done[i]};
  endfunction

  function automatic logic [W+1:0] dut_out(input int i);
    return (i == 0) ? {bcd1, busy1, done1} : {bcd4, busy4, done4};
  endfunction

  // Countdown value as a plain integer; elapsed-cycle counter reaches PRESCALE per unit.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rst) begin
        m_val[i] = 0; m_mode[i] = M_IDLE; m_ps[i] = 0;
      end else if (load) begin
        m_val[i] = clamp_value(load_val); m_mode[i] = M_IDLE; m_ps[i] = 0;
      end else begin
        case (m_mode[i])
          M_IDLE: if (start) begin
            if (m_val[i] == 0) begin m_mode[i] = M_DONE; m_done[i] = 1'b1; end
            else m_mode[i] = M_RUN;
          end
          M_RUN: if (pause) m_mode[i] = M_PAUSED;
          else begin
            m_ps[i]++;
            if (m_ps[i] == psc[i]) begin
              m_ps[i] = 0;
              m_val[i]--;
              if (m_val[i] == 0) begin m_mode[i] = M_DONE; m_done[i] = 1'b1; end
            end
          end
          M_PAUSED: if (start && !pause) m_mode[i] = M_RUN;
          default: ;
        endcase
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    cyc(); cyc();
    if ({bcd1, busy1, done1} !== 18'h0) begin
      fails++; $display("FAIL reset_p1: got %h expected %h", {bcd1, busy1, done1}, 18'h0);
    end
    tests++;
    if ({bcd4, busy4, done4} !== 18'h0) begin
      fails++; $display("FAIL reset_p4: got %h expected %h", {bcd4, busy4, done4}, 18'h0);
    end
    tests++;
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      if (dut_out(i) !== model_out(i)) begin
        fails++; $display("FAIL reset_release dut%0d: got %h expected %h", i, dut_out(i), model_out(i));
      end
      tests++;
    end
  endtask

  task automatic test_countdown();
    logic [W+1:0] exp_tab[3];
    exp_tab[0] = {16'h0002, 1'b1, 1'b0};
    exp_tab[1] = {16'h0001, 1'b1, 1'b0};
    exp_tab[2] = {16'h0000, 1'b0, 1'b1};
    load = 1'b1; load_val = 16'h0003; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    if ({bcd1, busy1, done1} !== {16'h0003, 1'b1, 1'b0}) begin
      fails++; $display("FAIL countdown_enter: got %h expected %h", {bcd1, busy1, done1}, {16'h0003, 1'b1, 1'b0});
    end
    tests++;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if ({bcd1, busy1, done1} !== exp_tab[k]) begin
        fails++; $display("FAIL countdown_step%0d: got %h expected %h", k, {bcd1, busy1, done1}, exp_tab[k]);
      end
      tests++;
      if (dut_out(1) !== model_out(1)) begin
        fails++; $display("FAIL countdown_p4 step%0d: got %h expected %h", k, dut_out(1), model_out(1));
      end
      tests++;
    end
    cyc();
    if ({bcd1, busy1, done1} !== 18'h0) begin
      fails++; $display("FAIL countdown_after_done: got %h expected %h", {bcd1, busy1, done1}, 18'h0);
    end
    tests++;
  endtask

  task automatic test_borrow();
    int done_cnt;
    done_cnt = 0;
    load = 1'b1; load_val = 16'h1000; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    if (bcd1 !== 16'h0999) begin
      fails++; $display("FAIL borrow_0999: got %h expected %h", bcd1, 16'h0999);
    end
    tests++;
    for (int k = 0; k < 999; k++) begin
      cyc();
      if (done1) done_cnt++;
      for (int i = 0; i < 2; i++) begin
        if (dut_out(i) !== model_out(i)) begin
          fails++; $display("FAIL borrow_run dut%0d cyc%0d: got %h expected %h", i, k, dut_out(i), model_out(i));
        end
        tests++;
      end
    end
    if (bcd1 !== 16'h0000 || done_cnt != 1) begin
      fails++; $display("FAIL borrow_end: got bcd %h done_pulses %0d expected 0000 and 1", bcd1, done_cnt);
    end
    tests++;
  endtask

  task automatic test_prescale();
    load = 1'b1; load_val = 16'h0002; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    if ({bcd4, busy4} !== {16'h0002, 1'b1}) begin
      fails++; $display("FAIL prescale_prepause: got %h expected %h", {bcd4, busy4}, {16'h0002, 1'b1});
    end
    tests++;
    pause = 1'b1; cyc(); pause = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if ({bcd4, busy4, done4} !== {16'h0002, 1'b1, 1'b0} || dut_out(1) !== model_out(1)) begin
        fails++; $display("FAIL prescale_hold cyc%0d: got %h expected %h", k, dut_out(1), {16'h0002, 1'b1, 1'b0});
      end
      tests++;
    end
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    if (bcd4 !== 16'h0002) begin
      fails++; $display("FAIL prescale_resume1: got %h expected %h", bcd4, 16'h0002);
    end
    tests++;
    cyc();
    if (bcd4 !== 16'h0001) begin
      fails++; $display("FAIL prescale_resume2: got %h expected %h", bcd4, 16'h0001);
    end
    tests++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (dut_out(1) !== model_out(1)) begin
        fails++; $display("FAIL prescale_tail cyc%0d: got %h expected %h", k, dut_out(1), model_out(1));
      end
      tests++;
    end
    if ({bcd4, busy4, done4} !== {16'h0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL prescale_done: got %h expected %h", {bcd4, busy4, done4}, {16'h0000, 1'b0, 1'b1});
    end
    tests++;
  endtask

  task automatic test_conflicts();
    load = 1'b1; load_val = 16'h0500; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
    if ({bcd1, busy1, done1} !== {16'h0499, 1'b1, 1'b0}) begin
      fails++; $display("FAIL conflict_run_pause: got %h expected %h", {bcd1, busy1, done1}, {16'h0499, 1'b1, 1'b0});
    end
    tests++;
    start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
    cyc();
    if ({bcd1, busy1} !== {16'h0499, 1'b1} || dut_out(0) !== model_out(0)) begin
      fails++; $display("FAIL conflict_paused_hold: got %h expected %h", dut_out(0), model_out(0));
    end
    tests++;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    if (bcd1 !== 16'h0498) begin
      fails++; $display("FAIL conflict_resume: got %h expected %h", bcd1, 16'h0498);
    end
    tests++;
    load = 1'b1; load_val = 16'h0321; cyc(); load = 1'b0;
    if ({bcd1, busy1, done1} !== {16'h0321, 1'b0, 1'b0}) begin
      fails++; $display("FAIL conflict_load_abort: got %h expected %h", {bcd1, busy1, done1}, {16'h0321, 1'b0, 1'b0});
    end
    tests++;
    cyc();
    for (int i = 0; i < 2; i++) begin
      if (dut_out(i) !== model_out(i)) begin
        fails++; $display("FAIL conflict_idle dut%0d: got %h expected %h", i, dut_out(i), model_out(i));
      end
      tests++;
    end
  endtask

  task automatic test_zero_load();
    load = 1'b1; load_val = 16'h0000; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    if ({bcd1, busy1, done1, bcd4, busy4, done4} !== {16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL zero_start_done: got %h %h expected %h", dut_out(0), dut_out(1), 18'h1);
    end
    tests++;
    cyc();
    if (done1 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL zero_done_fall: got %b%b expected 00", done1, done4);
    end
    tests++;
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; cyc(); start = 1'b0;
      if ({done1, done4, busy1, busy4} !== 4'b0000 || bcd1 !== 16'h0) begin
        fails++; $display("FAIL zero_restart%0d: got %h expected %h", k, dut_out(0), 18'h0);
      end
      tests++;
      cyc();
    end
  endtask

  task automatic test_clamp_reset();
    load = 1'b1; load_val = 16'hAF3C; cyc(); load = 1'b0;
    if (bcd1 !== 16'h9939 || bcd4 !== 16'h9939) begin
      fails++; $display("FAIL clamp: got %h %h expected %h", bcd1, bcd4, 16'h9939);
    end
    tests++;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    if (bcd1 !== 16'h9937) begin
      fails++; $display("FAIL clamp_run: got %h expected %h", bcd1, 16'h9937);
    end
    tests++;
    rst = 1'b1; cyc(); rst = 1'b0;
    if ({bcd1, busy1, done1, bcd4, busy4, done4} !== 36'h0) begin
      fails++; $display("FAIL midrun_reset: got %h %h expected 0", dut_out(0), dut_out(1));
    end
    tests++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? W'($urandom()) : to_bcd($urandom_range(0, 12));
      start = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 7) == 0);
      cyc();
      for (int i = 0; i < 2; i++) begin
        if (dut_out(i) !== model_out(i)) begin
          fails++; $display("FAIL random dut%0d cyc%0d: got %h expected %h", i, k, dut_out(i), model_out(i));
        end
        tests++;
      end
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_prescale();
    test_conflicts();
    test_zero_load();
    test_clamp_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
